// File: rtl/ysyx_22050710_inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular FIFO of
// (pc, inst) pairs with a valid/ready handshake on each side and a redirect flush.
module ysyx_22050710_inst_queue #(
   parameter int unsigned INST_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_in_valid,
   output logic                      o_in_ready,
   input  logic [DATA_WIDTH-1:0]     i_in_pc,
   input  logic [INST_WIDTH-1:0]     i_in_inst,
   output logic                      o_out_valid,
   input  logic                      i_out_ready,
   output logic [DATA_WIDTH-1:0]     o_out_pc,
   output logic [INST_WIDTH-1:0]     o_out_inst,
   input  logic                      i_flush,
   output logic [$clog2(DEPTH):0]    o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] pc_mem   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  push_c;
   logic                  pop_c;

   // Handshake status decodes registered occupancy only; no input feeds an output.
   assign o_in_ready  = (count != CNT_W'(DEPTH));
   assign o_out_valid = (count != '0);
   assign o_out_pc    = pc_mem[rd_ptr];
   assign o_out_inst  = inst_mem[rd_ptr];
   assign o_count     = count;

   always_comb begin
      push_c = i_in_valid && o_in_ready;
      pop_c  = o_out_valid && i_out_ready;
   end

   // Pointer and occupancy state; flush drops any same-cycle push or pop.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is cleared only by reset; flush leaves stale data behind the pointers.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else if (push_c && !i_flush) begin
         pc_mem[wr_ptr]   <= i_in_pc;
         inst_mem[wr_ptr] <= i_in_inst;
      end
   end

endmodule
